// File: rtl/qpsk_tx_pkg.sv
// Shared types and helpers for the QPSK TX symbol path.
// Holds the sequencer state encoding and the dibit Gray map.
package qpsk_tx_pkg;

  localparam int PHASE_W_DEF = 16;
  localparam int DIBIT_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RUN
  } state_t;

  // 00->0, 01->1, 11->2, 10->3
  function automatic logic [1:0] gray_map(
    input logic [1:0] d
  );
    return {d[1], d[1] ^ d[0]};
  endfunction

endpackage

// File: rtl/qpsk_symbol_sequencer_if.sv
// AXI-stream word channel from the TX FIFO.
// The sequencer is the slave; the FIFO is the master.
interface qpsk_symbol_sequencer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/qpsk_gray_diff_enc.sv
// Gray-maps one dibit and optionally accumulates it mod 4
// onto the current quadrant (differential QPSK).
module qpsk_gray_diff_enc
  import qpsk_tx_pkg::*;
#(
  parameter int DIFF_ENC = 1
) (
  input  logic [1:0] i_dibit,
  input  logic [1:0] i_quadrant,
  output logic [1:0] o_quadrant
);

  logic [1:0] w_gray;

  assign w_gray = gray_map(i_dibit);

  assign o_quadrant = (DIFF_ENC != 0)
                    ? i_quadrant + w_gray
                    : w_gray;

endmodule

// File: rtl/qpsk_symbol_sequencer.sv
// Unpacks FIFO words into dibits, one per symbol strobe,
// and drives the carrier phase quadrant to the modulator.
module qpsk_symbol_sequencer
  import qpsk_tx_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int SYMS_PER_WORD = DATA_W / 2,
  parameter int PHASE_W       = PHASE_W_DEF,
  parameter int DIFF_ENC      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                qpsk_go,
  input  logic                next_output,
  input  logic                clear_underflow,
  qpsk_symbol_sequencer_if.slave s_axis,
  output logic [PHASE_W-1:0]  phase_offset,
  output logic [1:0]          quadrant,
  output logic                symbol_strobe,
  output logic                underflow,
  output logic [15:0]         symbol_count
);

  localparam int CNT_W = $clog2(SYMS_PER_WORD + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_buf;
  logic [DATA_W-1:0]  w_buf_nxt;
  logic [CNT_W-1:0]   r_sym_left;
  logic [CNT_W-1:0]   w_sym_left_nxt;
  logic [1:0]         r_quad;
  logic [1:0]         w_quad_nxt;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] w_phase_nxt;
  logic               r_strobe;
  logic               w_strobe_nxt;
  logic               r_uf;
  logic               w_uf_nxt;
  logic [15:0]        r_cnt;
  logic [15:0]        w_cnt_nxt;
  logic [1:0]         w_enc_quad;
  logic               w_ready;
  logic               w_hs;

  assign w_ready       = (r_state == ST_FETCH);
  assign w_hs          = s_axis.tvalid & w_ready;
  assign s_axis.tready = w_ready;

  qpsk_gray_diff_enc #(
    .DIFF_ENC (DIFF_ENC)
  ) u_enc (
    .i_dibit    (r_buf[DIBIT_W-1:0]),
    .i_quadrant (r_quad),
    .o_quadrant (w_enc_quad)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_buf_nxt      = r_buf;
    w_sym_left_nxt = r_sym_left;
    w_quad_nxt     = r_quad;
    w_strobe_nxt   = 1'b0;
    w_uf_nxt       = r_uf & ~clear_underflow;
    w_cnt_nxt      = r_cnt;
    // Dropping go aborts everything, even a same-cycle strobe or load
    if (!qpsk_go) begin
      w_state_nxt    = ST_IDLE;
      w_buf_nxt      = '0;
      w_sym_left_nxt = '0;
      w_quad_nxt     = 2'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_FETCH;
          w_cnt_nxt   = 16'd0;
          w_quad_nxt  = 2'd0;
        end
        ST_FETCH: begin
          if (next_output) w_uf_nxt = 1'b1;
          if (w_hs) begin
            w_buf_nxt      = s_axis.tdata;
            w_sym_left_nxt = CNT_W'(SYMS_PER_WORD);
            w_state_nxt    = ST_RUN;
          end
        end
        ST_RUN: begin
          if (next_output) begin
            w_quad_nxt     = w_enc_quad;
            w_buf_nxt      = r_buf >> DIBIT_W;
            w_sym_left_nxt = r_sym_left - CNT_W'(1);
            w_strobe_nxt   = 1'b1;
            if (r_cnt != 16'hFFFF) w_cnt_nxt = r_cnt + 16'd1;
            if (r_sym_left == CNT_W'(1)) w_state_nxt = ST_FETCH;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_phase_nxt = {w_quad_nxt, {(PHASE_W-2){1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_buf      <= '0;
      r_sym_left <= '0;
      r_quad     <= 2'd0;
      r_phase    <= '0;
      r_strobe   <= 1'b0;
      r_uf       <= 1'b0;
      r_cnt      <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_buf      <= w_buf_nxt;
      r_sym_left <= w_sym_left_nxt;
      r_quad     <= w_quad_nxt;
      r_phase    <= w_phase_nxt;
      r_strobe   <= w_strobe_nxt;
      r_uf       <= w_uf_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign phase_offset  = r_phase;
  assign quadrant      = r_quad;
  assign symbol_strobe = r_strobe;
  assign underflow     = r_uf;
  assign symbol_count  = r_cnt;

endmodule

// File: tb/tb_qpsk_symbol_sequencer.sv
// Bench for qpsk_symbol_sequencer: a differential and an absolute
// instance share stimulus and are checked against a queue model.
module tb_qpsk_symbol_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic       nxt;
  logic       clr_u;
  logic [7:0] tdata;
  logic       tvalid;

  logic [15:0] ph_d, ph_a, cnt_d, cnt_a;
  logic [1:0]  q_d, q_a;
  logic        st_d, st_a, uf_d, uf_a;

  always #5 clk = ~clk;

  qpsk_symbol_sequencer_if #(.DATA_W(8)) ax_d ();
  qpsk_symbol_sequencer_if #(.DATA_W(8)) ax_a ();

  assign ax_d.tdata  = tdata;
  assign ax_d.tvalid = tvalid;
  assign ax_a.tdata  = tdata;
  assign ax_a.tvalid = tvalid;

  qpsk_symbol_sequencer #(.DATA_W(8), .DIFF_ENC(1)) dut_d (
    .clk             (clk),
    .rst             (rst),
    .qpsk_go         (go),
    .next_output     (nxt),
    .clear_underflow (clr_u),
    .s_axis          (ax_d),
    .phase_offset    (ph_d),
    .quadrant        (q_d),
    .symbol_strobe   (st_d),
    .underflow       (uf_d),
    .symbol_count    (cnt_d)
  );

  qpsk_symbol_sequencer #(.DATA_W(8), .DIFF_ENC(0)) dut_a (
    .clk             (clk),
    .rst             (rst),
    .qpsk_go         (go),
    .next_output     (nxt),
    .clear_underflow (clr_u),
    .s_axis          (ax_a),
    .phase_offset    (ph_a),
    .quadrant        (q_a),
    .symbol_strobe   (st_a),
    .underflow       (uf_a),
    .symbol_count    (cnt_a)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pops  = 0;
  bit hold_off = 0;
  logic [7:0] fifo[$];

  bit       m_armed;
  bit [1:0] m_dib[$];
  int       m_qa, m_qd, m_cnt;
  bit       m_uf, m_strobe;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int gray_ref(input int d);
    case (d)
      0: return 0;
      1: return 1;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    m_armed = 0; m_dib.delete();
    m_qa = 0; m_qd = 0; m_cnt = 0;
    m_uf = 0; m_strobe = 0;
  endtask

  task automatic model_edge(input bit g, input bit stb, input bit clr,
                            input bit tv, input logic [7:0] td);
    bit ready;
    int d, gv;
    ready = m_armed && m_dib.size() == 0;
    m_strobe = 0;
    if (clr) m_uf = 0;
    if (!g) begin
      m_armed = 0; m_dib.delete(); m_qa = 0; m_qd = 0;
    end else if (!m_armed) begin
      m_armed = 1; m_cnt = 0; m_qa = 0; m_qd = 0;
    end else if (ready) begin
      if (stb) m_uf = 1;
      if (tv) for (int i = 0; i < 4; i++) m_dib.push_back(2'(td >> (2*i)));
    end else if (stb) begin
      d = int'(m_dib.pop_front());
      gv = gray_ref(d);
      m_qa = gv;
      m_qd = (m_qd + gv) % 4;
      if (m_cnt < 65535) m_cnt++;
      m_strobe = 1;
    end
  endtask

  task automatic check_outs();
    check("quad_d",  q_d,   m_qd);
    check("quad_a",  q_a,   m_qa);
    check("phase_d", ph_d,  m_qd * 16384);
    check("phase_a", ph_a,  m_qa * 16384);
    check("strb_d",  st_d,  m_strobe);
    check("strb_a",  st_a,  m_strobe);
    check("uf_d",    uf_d,  m_uf);
    check("uf_a",    uf_a,  m_uf);
    check("cnt_d",   cnt_d, m_cnt);
    check("cnt_a",   cnt_a, m_cnt);
  endtask

  // one clock: drive at edge+1, check before and after the edge
  task automatic cyc(input bit stb, input bit clr);
    bit tv, hs, mr;
    logic [7:0] td;
    nxt = stb; clr_u = clr;
    tv = !hold_off && fifo.size() > 0;
    td = tv ? fifo[0] : 8'h00;
    tvalid = tv; tdata = td;
    mr = m_armed && m_dib.size() == 0;
    check("tready_d", ax_d.tready, mr);
    check("tready_a", ax_a.tready, mr);
    hs = tv && ax_d.tready;
    @(posedge clk);
    model_edge(go, stb, clr, tv, td);
    if (hs) begin fifo.delete(0); pops++; end
    #1;
    check_outs();
    nxt = 0; clr_u = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_q"},   {q_d, q_a}, 0);
    check({tag, "_ph"},  {ph_d, ph_a}, 0);
    check({tag, "_st"},  {st_d, st_a}, 0);
    check({tag, "_uf"},  {uf_d, uf_a}, 0);
    check({tag, "_cnt"}, {cnt_d, cnt_a}, 0);
    check({tag, "_rdy"}, {ax_d.tready, ax_a.tready}, 0);
  endtask

  initial begin
    int qprev, p0, c0;
    rst = 1; go = 0; nxt = 0; clr_u = 0; tdata = 0; tvalid = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 0;

    // absolute mapping of 0xB4
    fifo.push_back(8'hB4);
    go = 1;
    cyc(0, 0);
    cyc(0, 0);
    for (int k = 0; k < 4; k++) begin
      repeat (99) cyc(0, 0);
      cyc(1, 0);
      check("abs_q", q_a, k);
      check("abs_ph", ph_a, k << 14);
    end
    check("abs_refill_rdy", ax_a.tready, 1);
    check("abs_count", cnt_a, 4);

    // differential 0x55 0x55
    go = 0; cyc(0, 0);
    go = 1; cyc(0, 0);
    p0 = pops;
    fifo.push_back(8'h55);
    fifo.push_back(8'h55);
    for (int k = 0; k < 8; k++) begin
      repeat (4) cyc(0, 0);
      cyc(1, 0);
      check("diff_q", q_d, (k + 1) % 4);
    end
    cyc(0, 0);
    check("diff_pops", pops - p0, 2);

    // underflow in FETCH with nothing valid
    hold_off = 1;
    qprev = q_d;
    cyc(1, 0);
    check("uf_set", uf_d, 1);
    check("uf_qhold", q_d, qprev);
    check("uf_nostrb", st_d, 0);
    cyc(1, 1);
    check("uf_set_wins", uf_d, 1);
    cyc(0, 1);
    hold_off = 0;

    // handshake and strobe in the same FETCH cycle
    fifo.push_back(8'h1B);
    c0 = cnt_d;
    cyc(1, 0);
    check("hs_uf", uf_d, 1);
    check("hs_cnt", cnt_d, c0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0);
      cyc(1, 0);
    end
    cyc(0, 0);
    check("hs_four_syms", cnt_d, c0 + 4);

    // abort after two of four symbols
    fifo.push_back(8'hE4);
    cyc(0, 0);
    cyc(1, 0); cyc(0, 0);
    cyc(1, 0); cyc(0, 0);
    go = 0;
    cyc(0, 0);
    check("abort_q", {q_d, q_a}, 0);
    check("abort_rdy", ax_d.tready, 0);
    repeat (3) begin
      cyc(1, 0);
      check("abort_ign", {st_d, st_a}, 0);
    end
    fifo.push_back(8'h27);
    go = 1;
    cyc(0, 0);
    check("rearm_cnt", cnt_d, 0);
    check("rearm_rdy", ax_d.tready, 1);

    // asynchronous reset mid-RUN
    cyc(0, 0);
    cyc(1, 0);
    cyc(0, 0);
    fifo.push_back(8'h39);
    #3 rst = 1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    go = 0;
    @(posedge clk);
    #1 rst = 0;
    p0 = pops;
    repeat (3) cyc(0, 0);
    check("rst_nopop", pops - p0, 0);

    // randomized traffic
    go = 1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 59) == 0) go = ~go;
      if ($urandom_range(0, 5) == 0 && fifo.size() < 3)
        fifo.push_back(8'($urandom));
      hold_off = ($urandom_range(0, 7) == 0);
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
